// File: rtl/mult_scheduler.sv
// Two-requester scheduler for a shared 9x4 multiplier: builds a 9x8
// product from two nibble passes and returns it on a valid/ready port.
// Ports: req0_*/req1_* request channels, resp_* response channel,
// mul_x/mul_y/mul_product shared multiplier, busy, ops_count.
module mult_scheduler #(
    parameter int unsigned RR_INIT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [8:0]  req0_x,
    input  logic [7:0]  req0_y,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [8:0]  req1_x,
    input  logic [7:0]  req1_y,
    output logic        req1_ready,
    output logic        resp_valid,
    output logic        resp_id,
    output logic [16:0] resp_data,
    input  logic        resp_ready,
    output logic [8:0]  mul_x,
    output logic [3:0]  mul_y,
    input  logic [12:0] mul_product,
    output logic        busy,
    output logic [15:0] ops_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MUL_LO = 3'd1,
        MUL_HI = 3'd2,
        ACC    = 3'd3,
        RESP   = 3'd4
    } state_t;

    localparam logic PRIO_RST = RR_INIT[0];

    state_t      state_q, state_d;
    logic        prio_q, prio_d;
    logic [8:0]  x_q, x_d;
    logic [7:0]  y_q, y_d;
    logic        id_q, id_d;
    logic [12:0] acc_q, acc_d;
    logic [16:0] result_q, result_d;
    logic [15:0] ops_q, ops_d;

    logic        grant_any;
    logic        grant_id;
    logic        accept;
    logic        resp_hs;

    // Grant: the lone valid requester, or the priority holder on a tie.
    // Readys are masked while reset is held so nothing looks accepted.
    always_comb begin
        grant_any  = req0_valid | req1_valid;
        grant_id   = (req0_valid & req1_valid) ? prio_q : req1_valid;
        req0_ready = rst_n & (state_q == IDLE) & grant_any & ~grant_id;
        req1_ready = rst_n & (state_q == IDLE) & grant_any & grant_id;
        accept     = req0_ready | req1_ready;
        resp_hs    = (state_q == RESP) & resp_ready;
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            prio_q   <= PRIO_RST;
            x_q      <= '0;
            y_q      <= '0;
            id_q     <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
            ops_q    <= '0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            x_q      <= x_d;
            y_q      <= y_d;
            id_q     <= id_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            ops_q    <= ops_d;
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        x_d      = x_q;
        y_d      = y_q;
        id_d     = id_q;
        acc_d    = acc_q;
        result_d = result_q;
        ops_d    = ops_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    x_d     = grant_id ? req1_x : req0_x;
                    y_d     = grant_id ? req1_y : req0_y;
                    id_d    = grant_id;
                    prio_d  = ~grant_id;
                    state_d = MUL_LO;
                end
            end
            MUL_LO: state_d = MUL_HI;
            MUL_HI: begin
                // Product of the low nibble arrives this cycle.
                acc_d   = mul_product;
                state_d = ACC;
            end
            ACC: begin
                // High-nibble product arrives now; weight it by 16.
                result_d = {4'b0000, acc_q} + {mul_product, 4'b0000};
                state_d  = RESP;
            end
            RESP: begin
                if (resp_hs) begin
                    state_d = IDLE;
                    if (ops_q != 16'hFFFF) begin
                        ops_d = ops_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the registered state
    always_comb begin
        mul_x      = '0;
        mul_y      = '0;
        resp_valid = 1'b0;
        resp_id    = 1'b0;
        resp_data  = '0;
        unique case (state_q)
            MUL_LO: begin
                mul_x = x_q;
                mul_y = y_q[3:0];
            end
            MUL_HI: begin
                mul_x = x_q;
                mul_y = y_q[7:4];
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_id    = id_q;
                resp_data  = result_q;
            end
            default: ;
        endcase
        busy      = (state_q != IDLE);
        ops_count = ops_q;
    end

endmodule

// File: tb/tb_mult_scheduler.sv
// Directed bench for mult_scheduler with a registered 9x4 multiplier model.
module tb_mult_scheduler;

    logic        clk;
    logic        rst_n;
    logic        req0_valid;
    logic [8:0]  req0_x;
    logic [7:0]  req0_y;
    logic        req0_ready;
    logic        req1_valid;
    logic [8:0]  req1_x;
    logic [7:0]  req1_y;
    logic        req1_ready;
    logic        resp_valid;
    logic        resp_id;
    logic [16:0] resp_data;
    logic        resp_ready;
    logic [8:0]  mul_x;
    logic [3:0]  mul_y;
    logic [12:0] mul_product;
    logic        busy;
    logic [15:0] ops_count;

    int checks = 0;
    int errors = 0;
    int exp_ops = 0;

    mult_scheduler #(.RR_INIT(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_x     (req0_x),
        .req0_y     (req0_y),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_x     (req1_x),
        .req1_y     (req1_y),
        .req1_ready (req1_ready),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_ready (resp_ready),
        .mul_x      (mul_x),
        .mul_y      (mul_y),
        .mul_product(mul_product),
        .busy       (busy),
        .ops_count  (ops_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared multiplier: registered, result one cycle after operands.
    always @(posedge clk)
        mul_product <= {4'b0000, mul_x} * {9'b0, mul_y};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one request and returns what the response port shows.
    task automatic run_op(input bit who, input logic [8:0] x,
                          input logic [7:0] y, output int lat,
                          output logic [16:0] data, output logic id,
                          output bit to);
        int n;
        to = 1'b0;
        lat = 0;
        data = '0;
        id = 1'b0;
        if (who) begin
            req1_valid = 1'b1; req1_x = x; req1_y = y;
        end else begin
            req0_valid = 1'b1; req0_x = x; req0_y = y;
        end
        #1;
        n = 0;
        while (!(who ? req1_ready : req0_ready)) begin
            if (n == 20) begin
                to = 1'b1;
                req0_valid = 1'b0;
                req1_valid = 1'b0;
                return;
            end
            tick();
            n++;
        end
        tick();
        lat = 1;
        // Scramble inputs: captured operands must not follow them.
        if (who) begin
            req1_valid = 1'b0;
            req1_x = 9'($urandom);
            req1_y = 8'($urandom);
        end else begin
            req0_valid = 1'b0;
            req0_x = 9'($urandom);
            req0_y = 8'($urandom);
        end
        while (!resp_valid) begin
            if (lat == 20) begin
                to = 1'b1;
                return;
            end
            tick();
            lat++;
        end
        data = resp_data;
        id = resp_id;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_x = 9'd5; req0_y = 8'd5;
        req1_valid = 1'b1; req1_x = 9'd6; req1_y = 8'd6;
        resp_ready = 1'b1;
        #3;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++;
            $display("FAIL rst_ready got %b want 00", {req0_ready, req1_ready});
        end
        tick();
        checks++;
        if ({resp_valid, resp_id, resp_data, busy} !== 20'd0) begin
            errors++;
            $display("FAIL rst_resp got v%b id%b d%0d busy%b want 0",
                     resp_valid, resp_id, resp_data, busy);
        end
        checks++;
        if ({mul_x, mul_y} !== 13'd0 || ops_count !== 16'd0) begin
            errors++;
            $display("FAIL rst_mul got x%0d y%0d ops%0d want 0",
                     mul_x, mul_y, ops_count);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_priority();
        int n;
        resp_ready = 1'b1;
        req0_valid = 1'b1; req0_x = 9'd3; req0_y = 8'd5;
        req1_valid = 1'b1; req1_x = 9'd7; req1_y = 8'd16;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL prio_first got %b want 10", {req0_ready, req1_ready});
        end
        tick();
        req0_valid = 1'b0;
        req1_x = 9'h1FF;
        req1_y = 8'hAA;
        #1;
        checks++;
        if (req1_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL prio_busy got rdy%b busy%b want 0 1", req1_ready, busy);
        end
        n = 0;
        while (!resp_valid && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 17'd15 || resp_id !== 1'b0) begin
            errors++;
            $display("FAIL prio_r0 got v%b d%0d id%b want 1 15 0",
                     resp_valid, resp_data, resp_id);
        end
        checks++;
        if (req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL prio_resp_rdy got %b want 0", req1_ready);
        end
        req1_x = 9'd7;
        req1_y = 8'd16;
        tick();
        exp_ops++;
        checks++;
        if (req1_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL prio_second got rdy%b busy%b want 1 0", req1_ready, busy);
        end
        tick();
        req1_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 17'd112 || resp_id !== 1'b1) begin
            errors++;
            $display("FAIL prio_r1 got v%b d%0d id%b want 1 112 1",
                     resp_valid, resp_data, resp_id);
        end
        tick();
        exp_ops++;
        // Last grant went to req1, so priority is back with req0.
        req0_valid = 1'b1; req0_x = 9'd1; req0_y = 8'd1;
        req1_valid = 1'b1; req1_x = 9'd1; req1_y = 8'd1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL prio_rot got %b want 10", {req0_ready, req1_ready});
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
    endtask

    task automatic test_max();
        int lat;
        logic [16:0] d;
        logic id;
        bit to;
        resp_ready = 1'b1;
        run_op(1'b0, 9'd511, 8'd255, lat, d, id, to);
        checks++;
        if (to || lat !== 4) begin
            errors++;
            $display("FAIL max_lat got %0d to%b want 4", lat, to);
        end
        checks++;
        if (d !== 17'h1FD01 || id !== 1'b0) begin
            errors++;
            $display("FAIL max_data got %0d id%b want 130305 0", d, id);
        end
        tick();
        exp_ops++;
        checks++;
        if (ops_count !== 16'(exp_ops) || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL max_ops got %0d v%b want %0d 0",
                     ops_count, resp_valid, exp_ops);
        end
    endtask

    task automatic test_values();
        logic [8:0]  tx[4] = '{9'd1, 9'd0, 9'd511, 9'd300};
        logic [7:0]  ty[4] = '{8'hF0, 8'hFF, 8'h0F, 8'd0};
        logic [16:0] te[4] = '{17'd240, 17'd0, 17'd7665, 17'd0};
        int lat;
        logic [16:0] d;
        logic id;
        bit to;
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_op(1'(i), tx[i], ty[i], lat, d, id, to);
            checks++;
            if (to || lat !== 4 || d !== te[i] || id !== 1'(i)) begin
                errors++;
                $display("FAIL val%0d got d%0d id%b lat%0d want d%0d id%b lat4",
                         i, d, id, lat, te[i], 1'(i));
            end
            tick();
            exp_ops++;
        end
        checks++;
        if (ops_count !== 16'(exp_ops)) begin
            errors++;
            $display("FAIL val_ops got %0d want %0d", ops_count, exp_ops);
        end
    endtask

    task automatic test_mulport();
        resp_ready = 1'b1;
        req1_valid = 1'b1; req1_x = 9'h1A5; req1_y = 8'hC3;
        #1;
        checks++;
        if (mul_x !== 9'd0 || mul_y !== 4'd0 || req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL mp_idle got x%0h y%0h rdy%b want 0 0 1",
                     mul_x, mul_y, req1_ready);
        end
        tick();
        req1_valid = 1'b0;
        req1_x = 9'h0F0;
        req1_y = 8'h55;
        checks++;
        if (mul_x !== 9'h1A5 || mul_y !== 4'h3) begin
            errors++;
            $display("FAIL mp_lo got x%0h y%0h want 1a5 3", mul_x, mul_y);
        end
        tick();
        checks++;
        if (mul_x !== 9'h1A5 || mul_y !== 4'hC) begin
            errors++;
            $display("FAIL mp_hi got x%0h y%0h want 1a5 c", mul_x, mul_y);
        end
        tick();
        checks++;
        if (mul_x !== 9'd0 || mul_y !== 4'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mp_acc got x%0h y%0h busy%b want 0 0 1",
                     mul_x, mul_y, busy);
        end
        tick();
        checks++;
        if (mul_x !== 9'd0 || mul_y !== 4'd0 || resp_valid !== 1'b1
            || resp_data !== 17'd82095 || resp_id !== 1'b1) begin
            errors++;
            $display("FAIL mp_resp got x%0h y%0h v%b d%0d id%b want 0 0 1 82095 1",
                     mul_x, mul_y, resp_valid, resp_data, resp_id);
        end
        tick();
        exp_ops++;
    endtask

    task automatic test_stall();
        int lat;
        logic [16:0] d;
        logic id;
        bit to;
        resp_ready = 1'b0;
        run_op(1'b0, 9'd100, 8'd200, lat, d, id, to);
        checks++;
        if (to || lat !== 4 || d !== 17'd20000) begin
            errors++;
            $display("FAIL st_first got d%0d lat%0d to%b want 20000 4 0",
                     d, lat, to);
        end
        req0_valid = 1'b1; req0_x = 9'd9; req0_y = 8'd9;
        req1_valid = 1'b1; req1_x = 9'd9; req1_y = 8'd9;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (resp_valid !== 1'b1 || resp_data !== 17'd20000 || resp_id !== 1'b0
                || req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL st_hold%0d got v%b d%0d id%b r%b%b busy%b",
                         i, resp_valid, resp_data, resp_id,
                         req0_ready, req1_ready, busy);
            end
        end
        resp_ready = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++;
            $display("FAIL st_hs_rdy got %b want 00", {req0_ready, req1_ready});
        end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        exp_ops++;
        checks++;
        if (resp_valid !== 1'b0 || ops_count !== 16'(exp_ops)) begin
            errors++;
            $display("FAIL st_done got v%b ops%0d want 0 %0d",
                     resp_valid, ops_count, exp_ops);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [16:0] d;
        logic id;
        bit to;
        int seen;
        resp_ready = 1'b1;
        req0_valid = 1'b1; req0_x = 9'd50; req0_y = 8'd60;
        #1;
        tick();
        req0_valid = 1'b0;
        tick();
        checks++;
        if (mul_y !== 4'd3 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rm_inhi got y%0h busy%b want 3 1", mul_y, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, resp_valid, resp_id, resp_data, mul_x, mul_y,
             req0_ready, req1_ready} !== 35'd0 || ops_count !== 16'd0) begin
            errors++;
            $display("FAIL rm_async got busy%b v%b d%0d x%0d y%0d ops%0d want 0",
                     busy, resp_valid, resp_data, mul_x, mul_y, ops_count);
        end
        exp_ops = 0;
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (resp_valid || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL rm_noresp got %0d active cycles want 0", seen);
        end
        run_op(1'b1, 9'd2, 8'd3, lat, d, id, to);
        checks++;
        if (to || lat !== 4 || d !== 17'd6 || id !== 1'b1) begin
            errors++;
            $display("FAIL rm_after got d%0d id%b lat%0d want 6 1 4", d, id, lat);
        end
        tick();
        exp_ops++;
        checks++;
        if (ops_count !== 16'(exp_ops)) begin
            errors++;
            $display("FAIL rm_ops got %0d want %0d", ops_count, exp_ops);
        end
    endtask

    initial begin
        req0_valid = 1'b0; req0_x = '0; req0_y = '0;
        req1_valid = 1'b0; req1_x = '0; req1_y = '0;
        resp_ready = 1'b0;
        rst_n = 1'b0;
        test_reset();
        test_priority();
        test_max();
        test_values();
        test_mulport();
        test_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
